// File: rtl/dec_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Package : dec_pkg                                                |
// | Brief   : shared types and helpers for the 3-to-8 pulse decoder  |
// | Rev     : 1.0  initial release                                   |
// +------------------------------------------------------------------+
package dec_pkg;

  // Pulse sequencer states; encodings are fixed so waveforms stay readable.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    GAP   = 2'd2
  } state_t;

  localparam int ONEHOT_W = 8;

  // Bit n of the result is set when code equals n (code MSB is code[0]).
  function automatic logic [0:ONEHOT_W-1] onehot3(input logic [0:2] code);
    logic [0:ONEHOT_W-1] v;
    v       = '0;
    v[code] = 1'b1;
    return v;
  endfunction

endpackage
`default_nettype wire

// File: rtl/decoder38_comb.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module : decoder38_comb                                          |
// | Brief  : pure combinational 3-bit code to 8-bit one-hot decode   |
// | Rev    : 1.0  initial release                                    |
// +------------------------------------------------------------------+
module decoder38_comb
  import dec_pkg::*;
(
  input  logic [0:2]          i_code,
  output logic [0:ONEHOT_W-1] o_onehot
);

  assign o_onehot = onehot3(i_code);

endmodule
`default_nettype wire

// File: rtl/decoder38_pulse.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module : decoder38_pulse                                         |
// | Brief  : registered 3-to-8 decoder; accepts a code via valid/     |
// |          ready, drives its one-hot line HOLD_CYCLES clocks, then |
// |          idles GAP_CYCLES clocks before accepting again          |
// | Rev    : 1.0  initial release                                    |
// +------------------------------------------------------------------+
module decoder38_pulse
  import dec_pkg::*;
#(
  parameter int HOLD_CYCLES = 4,
  parameter int GAP_CYCLES  = 1,
  parameter int CNT_W       = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                enable,
  input  logic [0:2]          A,
  input  logic                valid,
  output logic                ready,
  output logic [0:ONEHOT_W-1] Q,
  output logic                busy,
  output logic                done
);

  // Refuse to build a configuration whose counter would need to wrap.
  if (HOLD_CYCLES < 1 || GAP_CYCLES < 0 ||
      (HOLD_CYCLES - 1) > (2**CNT_W - 1) ||
      (GAP_CYCLES - 1) > (2**CNT_W - 1)) begin : g_param_check
    $error("decoder38_pulse: HOLD_CYCLES/GAP_CYCLES do not fit CNT_W");
  end

  localparam logic [CNT_W-1:0] c_hold_load = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] c_gap_load  = CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam bit               c_has_gap   = (GAP_CYCLES > 0);

  state_t              r_state;
  state_t              w_state_nxt;
  logic [CNT_W-1:0]    r_cnt;
  logic [CNT_W-1:0]    w_cnt_nxt;
  logic [0:2]          r_code;
  logic [0:2]          w_code_nxt;
  logic [0:ONEHOT_W-1] w_onehot_nxt;
  logic [0:ONEHOT_W-1] w_q_nxt;
  logic                w_busy_nxt;
  logic                w_done_nxt;
  logic [0:ONEHOT_W-1] r_q;
  logic                r_busy;
  logic                r_done;

  // Gating with rst_n keeps ready low while the block is held in reset,
  // so an upstream producer cannot believe a code was taken.
  assign ready = rst_n & enable & (r_state == IDLE);

  // Decode of the code that will be latched at the coming edge; the
  // registered copy of this is what appears on Q.
  decoder38_comb u_dec (
    .i_code   (w_code_nxt),
    .o_onehot (w_onehot_nxt)
  );

  // Next-state, counter and next-output computation.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_code_nxt  = r_code;
    if (!enable) begin
      // Abort from any state; nothing of the pulse survives.
      w_state_nxt = IDLE;
      w_cnt_nxt   = '0;
    end else begin
      case (r_state)
        IDLE: begin
          // ready is implied here (enable high, state IDLE).
          if (valid) begin
            w_state_nxt = DRIVE;
            w_cnt_nxt   = c_hold_load;
            w_code_nxt  = A;
          end
        end
        DRIVE: begin
          if (r_cnt == '0) begin
            if (c_has_gap) begin
              w_state_nxt = GAP;
              w_cnt_nxt   = c_gap_load;
            end else begin
              w_state_nxt = IDLE;
              w_cnt_nxt   = '0;
            end
          end else begin
            w_cnt_nxt = r_cnt - CNT_W'(1);
          end
        end
        GAP: begin
          if (r_cnt == '0) begin
            w_state_nxt = IDLE;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = r_cnt - CNT_W'(1);
          end
        end
        default: begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
        end
      endcase
    end
  end

  // Outputs are computed from the next state so that, once registered,
  // they line up exactly with the state they describe.
  always_comb begin
    w_q_nxt    = '0;
    w_busy_nxt = (w_state_nxt != IDLE);
    w_done_nxt = 1'b0;
    if (w_state_nxt == DRIVE) begin
      w_q_nxt    = w_onehot_nxt;
      w_done_nxt = (w_cnt_nxt == '0);
    end
  end

  // State, counter, latched code and registered outputs; reset clears
  // the outputs immediately, independent of the clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_code  <= '0;
      r_q     <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_code  <= w_code_nxt;
      r_q     <= w_q_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
    end
  end

  assign Q    = r_q;
  assign busy = r_busy;
  assign done = r_done;

`ifndef SYNTHESIS
  // An unknown code on an accepted handshake would latch garbage.
  always_ff @(posedge clk) begin
    if (rst_n && valid && ready) begin
      assert (!$isunknown(A))
        else $error("decoder38_pulse: A is X/Z on accept");
    end
  end
`endif

endmodule
`default_nettype wire
